// File: rtl/cmp_pkg.sv
// Shared core/memory parameters and small helpers.
// Imported by the data-memory response path and the core.
package cmp_pkg;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;
    localparam int IDX_W  = 8;
    localparam int CNT_W  = 16;

    function automatic logic [0:CNT_W-1] sat_inc(input logic [0:CNT_W-1] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data storage: synchronous write, registered read.
// Contents are never reset; the read register only moves on rd_en.
module dmem_array #(
    parameter int DATA_W = cmp_pkg::DATA_W,
    parameter int DEPTH  = cmp_pkg::DEPTH,
    parameter int IDX_W  = cmp_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [0:DATA_W-1] wr_data,
    output logic [0:DATA_W-1] rd_data
);

    logic [0:DATA_W-1] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory response path: range check, load-valid pipeline,
// sticky address error and saturating access counters.
module dmem_resp #(
    parameter int DATA_W = cmp_pkg::DATA_W,
    parameter int DEPTH  = cmp_pkg::DEPTH,
    parameter int IDX_W  = cmp_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memEn,
    input  logic              memWrEn,
    input  logic [0:31]       addr_in,
    input  logic [0:DATA_W-1] wr_data,
    output logic [0:DATA_W-1] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    output logic [0:15]       rd_cnt,
    output logic [0:15]       wr_cnt
);

    import cmp_pkg::*;

    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              load;
    logic              store;
    logic              arr_we;
    logic              arr_re;
    logic [0:DATA_W-1] arr_q;

    logic              valid_q;
    logic              zero_q;
    logic              err_q;
    logic [0:15]       rd_cnt_q;
    logic [0:15]       wr_cnt_q;

    assign idx      = addr_in[32-IDX_W:31];
    assign in_range = ~|addr_in[0:31-IDX_W];
    assign load     = memEn & ~memWrEn;
    assign store    = memEn & memWrEn;
    assign arr_we   = store & in_range & ~reset;
    assign arr_re   = load & in_range & ~reset;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_we),
        .rd_en   (arr_re),
        .idx     (idx),
        .wr_data (wr_data),
        .rd_data (arr_q)
    );

    // zero_q selects an all-zero load result (after reset or an
    // out-of-range load) without disturbing the array read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            valid_q <= load;
            if (load) begin
                zero_q <= ~in_range;
            end
            if (memEn && !in_range) begin
                err_q <= 1'b1;
            end
            if (arr_re) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (arr_we) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
        end
    end

    // Outputs read as zero for the whole cycle reset is high, which also
    // kills a load's valid pulse when reset lands right behind it.
    assign rd_valid = valid_q & ~reset;
    assign addr_err = err_q & ~reset;
    assign rd_cnt   = reset ? '0 : rd_cnt_q;
    assign wr_cnt   = reset ? '0 : wr_cnt_q;
    assign rd_data  = (reset || zero_q) ? '0 : arr_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: reference model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_dmem_resp;

    localparam int DW    = 64;
    localparam int DEPTH = 256;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          memEn   = 1'b0;
    logic          memWrEn = 1'b0;
    logic [31:0]   addr_in = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          addr_err;
    logic [15:0]   rd_cnt;
    logic [15:0]   wr_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    logic [DW-1:0] e_rd;
    bit            e_rd_known = 1'b0;
    bit            e_valid = 1'b0;
    bit            e_err = 1'b0;
    int            e_rc = 0;
    int            e_wc = 0;
    bit            armed = 1'b0;

    always #5 clk = ~clk;

    dmem_resp dut (
        .clk      (clk),
        .reset    (reset),
        .memEn    (memEn),
        .memWrEn  (memWrEn),
        .addr_in  (addr_in),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .addr_err (addr_err),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // What one clock edge must do, from the access rules alone.
    task automatic model_edge();
        int i;
        if (reset) begin
            e_rd       = '0;
            e_rd_known = 1'b1;
            e_valid    = 1'b0;
            e_err      = 1'b0;
            e_rc       = 0;
            e_wc       = 0;
            armed      = 1'b1;
        end else begin
            e_valid = 1'b0;
            if (memEn) begin
                i = int'(addr_in % DEPTH);
                if (memWrEn) begin
                    if (addr_in < DEPTH) begin
                        m_mem[i]   = wr_data;
                        m_known[i] = 1'b1;
                        if (e_wc < 65535) e_wc++;
                    end else begin
                        e_err = 1'b1;
                    end
                end else begin
                    e_valid = 1'b1;
                    if (addr_in < DEPTH) begin
                        e_rd       = m_mem[i];
                        e_rd_known = m_known[i];
                        if (e_rc < 65535) e_rc++;
                    end else begin
                        e_rd       = '0;
                        e_rd_known = 1'b1;
                        e_err      = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("m_rd_valid", rd_valid, e_valid);
        chk("m_addr_err", addr_err, e_err);
        chk("m_rd_cnt", rd_cnt, e_rc);
        chk("m_wr_cnt", wr_cnt, e_wc);
        if (e_rd_known) chk("m_rd_data", rd_data, e_rd);
    endtask

    // Inputs are applied just after a falling edge; returns just after
    // the next falling edge, once the rising edge has been absorbed.
    task automatic cyc(input bit r, input bit en, input bit we,
                       input logic [31:0] a, input logic [DW-1:0] d);
        reset   = r;
        memEn   = en;
        memWrEn = we;
        addr_in = a;
        wr_data = d;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, '0);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                model_edge();
            end
            forever begin
                @(negedge clk);
                if (armed) compare();
            end
        join_none

        @(negedge clk);
        #1;
        cyc(1'b1, 1'b1, 1'b1, 32'h5, 64'h1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, '0);
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        chk("rst_rd_cnt", rd_cnt, 16'h0);
        chk("rst_wr_cnt", wr_cnt, 16'h0);

        // store then immediate load of the same word
        cyc(1'b0, 1'b1, 1'b1, 32'h5, 64'hDEADBEEF_0123_4567);
        cyc(1'b0, 1'b1, 1'b0, 32'h5, '0);
        chk("raw_data", rd_data, 64'hDEADBEEF_0123_4567);
        chk("raw_valid", rd_valid, 1'b1);
        idle();
        chk("hold_valid", rd_valid, 1'b0);
        chk("hold_data", rd_data, 64'hDEADBEEF_0123_4567);

        // back-to-back loads
        cyc(1'b1, 1'b0, 1'b0, 32'h0, '0);
        for (int k = 1; k <= 3; k++)
            cyc(1'b0, 1'b1, 1'b1, k, k);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, k, '0);
            chk("b2b_data", rd_data, k);
            chk("b2b_valid", rd_valid, 1'b1);
        end
        idle();
        chk("b2b_rd_cnt", rd_cnt, 16'd3);
        chk("b2b_wr_cnt", wr_cnt, 16'd3);

        // out-of-range store leaves array and wr_cnt alone
        cyc(1'b0, 1'b1, 1'b1, 32'h0, 64'hA5A5);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0100, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("oor_st_err", addr_err, 1'b1);
        chk("oor_st_wr_cnt", wr_cnt, 16'd4);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, '0);
        chk("oor_st_arr0", rd_data, 64'hA5A5);

        // out-of-range load returns zero, error stays sticky
        cyc(1'b1, 1'b0, 1'b0, 32'h0, '0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, '0);
        chk("persist_arr0", rd_data, 64'hA5A5);
        cyc(1'b0, 1'b1, 1'b0, 32'h0001_0000, '0);
        chk("oor_ld_data", rd_data, 64'h0);
        chk("oor_ld_valid", rd_valid, 1'b1);
        chk("oor_ld_err", addr_err, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 32'h9, 64'h99);
        cyc(1'b0, 1'b1, 1'b0, 32'h9, '0);
        chk("sticky_data", rd_data, 64'h99);
        chk("sticky_err", addr_err, 1'b1);
        chk("sticky_rd_cnt", rd_cnt, 16'd2);

        // write qualifier without enable is ignored
        cyc(1'b0, 1'b1, 1'b1, 32'h7, 64'h77);
        cyc(1'b0, 1'b0, 1'b1, 32'h7, 64'hBAD);
        cyc(1'b0, 1'b1, 1'b0, 32'h7, '0);
        chk("nowe_data", rd_data, 64'h77);
        chk("nowe_wr_cnt", wr_cnt, 16'd2);

        // reset right behind a load suppresses its valid pulse
        cyc(1'b0, 1'b1, 1'b0, 32'h9, '0);
        chk("pre_rst_valid", rd_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("sup_valid", rd_valid, 1'b0);
        chk("sup_data", rd_data, 64'h0);
        chk("sup_err", addr_err, 1'b0);
        chk("sup_rd_cnt", rd_cnt, 16'h0);
        chk("sup_wr_cnt", wr_cnt, 16'h0);
        @(negedge clk);
        #1;
        idle();
        chk("post_rst_valid", rd_valid, 1'b0);

        // drive wr_cnt to saturation
        for (int k = 0; e_wc < 65534; k++)
            cyc(1'b0, 1'b1, 1'b1, k % DEPTH, k);
        chk("sat_fffe", wr_cnt, 16'hFFFE);
        cyc(1'b0, 1'b1, 1'b1, 32'h11, 64'h1111);
        chk("sat_ffff_a", wr_cnt, 16'hFFFF);
        cyc(1'b0, 1'b1, 1'b1, 32'h12, 64'h2222);
        chk("sat_ffff_b", wr_cnt, 16'hFFFF);
        cyc(1'b0, 1'b1, 1'b0, 32'h12, '0);
        chk("sat_rd_back", rd_data, 64'h2222);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
